pipeline_reg_ex_fwd: RTL and testbench
======================================

Name: pipeline_reg_ex_fwd

Overview:
- Parametrised execute-stage pipeline register: successor to the fixed 32-bit EX register.
- Adds a valid bit, stall (hold), flush (bubble) and synchronous reset.
- Provides a qualified combinational raw bypass of the incoming ALU result.
- Adds a two-operand forwarding and load-use detection unit, plus a saturating stall counter.
- Sits between the ALU output and the MEM stage; its forwarding outputs feed the operand muxes in front of the ALU.

Parameters:
- XLEN, 32: data width of the ALU value and forwarded operands.
- REG_ADDR_W, 5: register-select width.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  incoming ID/ALU slot holds a real instruction.
- stall  in  1  hold registered contents this cycle.
- flush  in  1  load a bubble this cycle.
- ID_wr_en  in  1  incoming instruction writes rd.
- ID_mem_en  in  1  incoming instruction accesses memory.
- ID_mem_wr  in  1  incoming memory access is a store.
- ID_rd_sel  in  REG_ADDR_W  incoming destination register.
- ID_alu_val  in  XLEN  incoming ALU result.
- rs1_sel  in  REG_ADDR_W  source register 1 of the operand consumer.
- rs2_sel  in  REG_ADDR_W  source register 2 of the operand consumer.
- EX_valid  out  1  registered slot is valid.
- EX_wr_en  out  1  registered write enable.
- EX_mem_en  out  1  registered memory enable.
- EX_mem_wr  out  1  registered store flag.
- EX_rd_sel  out  REG_ADDR_W  registered destination register.
- EX_alu_val  out  XLEN  registered ALU result.
- EX_raw_sel  out  REG_ADDR_W  combinational bypass destination, 0 when not qualified.
- EX_raw_val  out  XLEN  combinational bypass value, 0 when not qualified.
- fwd_rs1_hit  out  1  forward valid for rs1.
- fwd_rs1_val  out  XLEN  forwarded rs1 value.
- fwd_rs2_hit  out  1  forward valid for rs2.
- fwd_rs2_val  out  XLEN  forwarded rs2 value.
- load_use_hazard  out  1  a source matches a pending load destination.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Priority on every rising clk edge: rst > flush > stall > load.
- rst=1: all registered outputs go to 0 (EX_valid, EX_wr_en, EX_mem_en, EX_mem_wr, EX_rd_sel, EX_alu_val, stall_cnt). This applies even mid-stall or mid-flush.
- flush=1 (rst=0): EX_valid, EX_wr_en, EX_mem_en and EX_mem_wr become 0. EX_rd_sel and EX_alu_val become 0. A simultaneous stall is ignored.
- stall=1 (rst=0, flush=0): all EX_* registers hold their values. stall_cnt increments by 1 and saturates at all-ones (no wrap).
- Otherwise (load): EX_valid <= in_valid. Control fields load from ID_* gated by in_valid (forced to 0 when in_valid=0). EX_rd_sel and EX_alu_val load unconditionally.
- Latency: 1 cycle from ID_* to EX_*.
- raw_q, combinational: in_valid & ID_wr_en & (ID_rd_sel != 0) & ~(ID_mem_en & ~ID_mem_wr).
  - EX_raw_sel = raw_q ? ID_rd_sel : 0.
  - EX_raw_val = raw_q ? ID_alu_val : 0.
  - Not affected by stall or flush.
- ex_q, combinational: EX_valid & EX_wr_en & (EX_rd_sel != 0) & ~(EX_mem_en & ~EX_mem_wr).
- Forwarding, per source s in {rs1, rs2}, fully combinational:
  - s_sel == 0: never hit; value 0.
  - raw_q & ID_rd_sel == s_sel: hit, value ID_alu_val. The younger producer wins.
  - else ex_q & EX_rd_sel == s_sel: hit, value EX_alu_val.
  - else: hit 0, value 0.
- load_use_hazard = 1 when any nonzero s_sel equals the rd of a pending load: either in_valid & ID_wr_en & ID_mem_en & ~ID_mem_wr on the ID side, or the same condition on the registered EX slot. A load is never a forwarding source.
- Stores (mem_wr=1) with wr_en=1 forward like ALU ops; wr_en=0 never forwards.

Test Plan:
- Reset then plain load: rst=1 for 2 cycles, then in_valid=1, ID_wr_en=1, rd=5, alu=0xDEADBEEF. Required: all outputs 0 during reset; next cycle EX_valid=1, EX_rd_sel=5, EX_alu_val=0xDEADBEEF.
- Stall: with rd=5/0x11 registered, stall=1 for 3 cycles while ID presents rd=6/0x22. Required: EX holds 5/0x11 and stall_cnt=3; after release, EX shows 6/0x22.
- Flush with stall: flush=1 and stall=1 in the same cycle. Required: EX_valid=0 and all controls 0; stall_cnt unchanged.
- Forward priority: EX holds rd=7/0x100, ID presents rd=7/0x200, rs1=7, rs2=7. Required: both hits=1 with value 0x200. Then remove ID (in_valid=0): both values 0x100. With rs1=0: hit=0.
- Load-use: ID presents a load to rd=3, rs2=3. Required: load_use_hazard=1, fwd_rs2_hit=0, EX_raw_sel=0. One cycle later, with the load registered: hazard still 1.
- Saturation (CNT_W=4): hold stall for 20 cycles. Required: stall_cnt=15; rst mid-stall gives stall_cnt=0 on the next edge.

Source files
------------

// File: rtl/pipeline_reg_ex_fwd_if.sv
// pipeline_reg_ex_fwd_if: ID-side inputs and EX/forwarding outputs of the execute register.
interface pipeline_reg_ex_fwd_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic                  ID_wr_en;
    logic                  ID_mem_en;
    logic                  ID_mem_wr;
    logic [REG_ADDR_W-1:0] ID_rd_sel;
    logic [XLEN-1:0]       ID_alu_val;
    logic [REG_ADDR_W-1:0] rs1_sel;
    logic [REG_ADDR_W-1:0] rs2_sel;
    logic                  EX_valid;
    logic                  EX_wr_en;
    logic                  EX_mem_en;
    logic                  EX_mem_wr;
    logic [REG_ADDR_W-1:0] EX_rd_sel;
    logic [XLEN-1:0]       EX_alu_val;
    logic [REG_ADDR_W-1:0] EX_raw_sel;
    logic [XLEN-1:0]       EX_raw_val;
    logic                  fwd_rs1_hit;
    logic [XLEN-1:0]       fwd_rs1_val;
    logic                  fwd_rs2_hit;
    logic [XLEN-1:0]       fwd_rs2_val;
    logic                  load_use_hazard;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output in_valid, stall, flush, ID_wr_en, ID_mem_en, ID_mem_wr, ID_rd_sel, ID_alu_val,
               rs1_sel, rs2_sel,
        input  EX_valid, EX_wr_en, EX_mem_en, EX_mem_wr, EX_rd_sel, EX_alu_val, EX_raw_sel,
               EX_raw_val, fwd_rs1_hit, fwd_rs1_val, fwd_rs2_hit, fwd_rs2_val, load_use_hazard,
               stall_cnt
    );

    modport slave (
        input  in_valid, stall, flush, ID_wr_en, ID_mem_en, ID_mem_wr, ID_rd_sel, ID_alu_val,
               rs1_sel, rs2_sel,
        output EX_valid, EX_wr_en, EX_mem_en, EX_mem_wr, EX_rd_sel, EX_alu_val, EX_raw_sel,
               EX_raw_val, fwd_rs1_hit, fwd_rs1_val, fwd_rs2_hit, fwd_rs2_val, load_use_hazard,
               stall_cnt
    );
endinterface

// File: rtl/pipeline_reg_ex_fwd.sv
// pipeline_reg_ex_fwd: EX pipeline register with raw bypass, operand forwarding and load-use detect.
module pipeline_reg_ex_fwd #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic rst,
    pipeline_reg_ex_fwd_if.slave bus
);
    logic                  ex_valid, ex_wr_en, ex_mem_en, ex_mem_wr;
    logic [REG_ADDR_W-1:0] ex_rd_sel;
    logic [XLEN-1:0]       ex_alu_val;
    logic [CNT_W-1:0]      cnt;
    logic                  raw_q, ex_q, id_ld, ex_ld;
    logic                  id_m1, id_m2, ex_m1, ex_m2;

    always_ff @(posedge clk) begin
        if (rst) begin
            {ex_valid, ex_wr_en, ex_mem_en, ex_mem_wr} <= '0;
            ex_rd_sel  <= '0;
            ex_alu_val <= '0;
            cnt        <= '0;
        end else if (bus.flush) begin
            {ex_valid, ex_wr_en, ex_mem_en, ex_mem_wr} <= '0;
            ex_rd_sel  <= '0;
            ex_alu_val <= '0;
        end else if (bus.stall) begin
            cnt <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
        end else begin
            ex_valid   <= bus.in_valid;
            ex_wr_en   <= bus.in_valid & bus.ID_wr_en;
            ex_mem_en  <= bus.in_valid & bus.ID_mem_en;
            ex_mem_wr  <= bus.in_valid & bus.ID_mem_wr;
            ex_rd_sel  <= bus.ID_rd_sel;
            ex_alu_val <= bus.ID_alu_val;
        end
    end

    // Loads write rd too, but their data is not ready here, so they never forward.
    assign raw_q = bus.in_valid & bus.ID_wr_en & (|bus.ID_rd_sel) & ~(bus.ID_mem_en & ~bus.ID_mem_wr);
    assign ex_q  = ex_valid & ex_wr_en & (|ex_rd_sel) & ~(ex_mem_en & ~ex_mem_wr);
    assign id_ld = bus.in_valid & bus.ID_wr_en & bus.ID_mem_en & ~bus.ID_mem_wr;
    assign ex_ld = ex_valid & ex_wr_en & ex_mem_en & ~ex_mem_wr;

    assign id_m1 = (|bus.rs1_sel) & (bus.ID_rd_sel == bus.rs1_sel);
    assign id_m2 = (|bus.rs2_sel) & (bus.ID_rd_sel == bus.rs2_sel);
    assign ex_m1 = (|bus.rs1_sel) & (ex_rd_sel == bus.rs1_sel);
    assign ex_m2 = (|bus.rs2_sel) & (ex_rd_sel == bus.rs2_sel);

    assign bus.EX_valid   = ex_valid;
    assign bus.EX_wr_en   = ex_wr_en;
    assign bus.EX_mem_en  = ex_mem_en;
    assign bus.EX_mem_wr  = ex_mem_wr;
    assign bus.EX_rd_sel  = ex_rd_sel;
    assign bus.EX_alu_val = ex_alu_val;
    assign bus.stall_cnt  = cnt;

    assign bus.EX_raw_sel = raw_q ? bus.ID_rd_sel : '0;
    assign bus.EX_raw_val = raw_q ? bus.ID_alu_val : '0;

    // The younger ID-side producer takes precedence over the registered one.
    assign bus.fwd_rs1_hit = (raw_q & id_m1) | (ex_q & ex_m1);
    assign bus.fwd_rs1_val = (raw_q & id_m1) ? bus.ID_alu_val : (ex_q & ex_m1) ? ex_alu_val : '0;
    assign bus.fwd_rs2_hit = (raw_q & id_m2) | (ex_q & ex_m2);
    assign bus.fwd_rs2_val = (raw_q & id_m2) ? bus.ID_alu_val : (ex_q & ex_m2) ? ex_alu_val : '0;

    assign bus.load_use_hazard = (id_ld & (id_m1 | id_m2)) | (ex_ld & (ex_m1 | ex_m2));
endmodule

// File: tb/tb_pipeline_reg_ex_fwd.sv
// tb_pipeline_reg_ex_fwd: directed plus random stimulus checked against a behavioural slot model.
module tb_pipeline_reg_ex_fwd;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0;
    logic rst = 1;
    int pass = 0, total = 0;

    pipeline_reg_ex_fwd_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(CW)) bus ();
    pipeline_reg_ex_fwd #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // model of the registered EX slot
    bit m_valid, m_wr, m_men, m_mwr;
    int m_rd;
    logic [31:0] m_alu;
    int m_cnt;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    endtask

    task automatic drive(input bit v, st, fl, wr, me, mw, input int rd, input logic [31:0] alu,
                         input int s1, s2);
        bus.in_valid = v; bus.stall = st; bus.flush = fl;
        bus.ID_wr_en = wr; bus.ID_mem_en = me; bus.ID_mem_wr = mw;
        bus.ID_rd_sel = 5'(rd); bus.ID_alu_val = alu;
        bus.rs1_sel = 5'(s1); bus.rs2_sel = 5'(s2);
    endtask

    task automatic check_model();
        bit id_prod, ex_prod, id_load, ex_load, haz;
        int src[2];
        bit ehit[2];
        logic [31:0] eval[2];
        id_prod = bus.in_valid && bus.ID_wr_en && bus.ID_rd_sel != 0 && !(bus.ID_mem_en && !bus.ID_mem_wr);
        ex_prod = m_valid && m_wr && m_rd != 0 && !(m_men && !m_mwr);
        id_load = bus.in_valid && bus.ID_wr_en && bus.ID_mem_en && !bus.ID_mem_wr;
        ex_load = m_valid && m_wr && m_men && !m_mwr;
        src[0] = int'(bus.rs1_sel);
        src[1] = int'(bus.rs2_sel);
        haz = 0;
        for (int i = 0; i < 2; i++) begin
            ehit[i] = 0; eval[i] = 0;
            if (src[i] != 0) begin
                if (id_prod && int'(bus.ID_rd_sel) == src[i]) begin ehit[i] = 1; eval[i] = bus.ID_alu_val; end
                else if (ex_prod && m_rd == src[i]) begin ehit[i] = 1; eval[i] = m_alu; end
                if ((id_load && int'(bus.ID_rd_sel) == src[i]) || (ex_load && m_rd == src[i])) haz = 1;
            end
        end
        chk("EX_valid", 32'(bus.EX_valid), 32'(m_valid));
        chk("EX_wr_en", 32'(bus.EX_wr_en), 32'(m_wr));
        chk("EX_mem_en", 32'(bus.EX_mem_en), 32'(m_men));
        chk("EX_mem_wr", 32'(bus.EX_mem_wr), 32'(m_mwr));
        chk("EX_rd_sel", 32'(bus.EX_rd_sel), 32'(m_rd));
        chk("EX_alu_val", bus.EX_alu_val, m_alu);
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        chk("EX_raw_sel", 32'(bus.EX_raw_sel), id_prod ? 32'(bus.ID_rd_sel) : 32'd0);
        chk("EX_raw_val", bus.EX_raw_val, id_prod ? bus.ID_alu_val : 32'd0);
        chk("fwd_rs1_hit", 32'(bus.fwd_rs1_hit), 32'(ehit[0]));
        chk("fwd_rs1_val", bus.fwd_rs1_val, eval[0]);
        chk("fwd_rs2_hit", 32'(bus.fwd_rs2_hit), 32'(ehit[1]));
        chk("fwd_rs2_val", bus.fwd_rs2_val, eval[1]);
        chk("load_use_hazard", 32'(bus.load_use_hazard), 32'(haz));
    endtask

    // check current cycle, take the edge, advance the model from the inputs that were sampled
    task automatic cyc();
        check_model();
        @(posedge clk);
        if (rst) begin
            {m_valid, m_wr, m_men, m_mwr} = '0; m_rd = 0; m_alu = 0; m_cnt = 0;
        end else if (bus.flush) begin
            {m_valid, m_wr, m_men, m_mwr} = '0; m_rd = 0; m_alu = 0;
        end else if (bus.stall) begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else begin
            m_valid = bus.in_valid;
            m_wr  = bus.in_valid && bus.ID_wr_en;
            m_men = bus.in_valid && bus.ID_mem_en;
            m_mwr = bus.in_valid && bus.ID_mem_wr;
            m_rd  = int'(bus.ID_rd_sel);
            m_alu = bus.ID_alu_val;
        end
        #1;
    endtask

    initial begin
        {m_valid, m_wr, m_men, m_mwr} = '0; m_rd = 0; m_alu = 0; m_cnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        #1;
        repeat (2) cyc();
        #2;
        chk("rst_valid", 32'(bus.EX_valid), 0);
        chk("rst_alu", bus.EX_alu_val, 0);
        chk("rst_cnt", 32'(bus.stall_cnt), 0);
        rst = 0;

        drive(1, 0, 0, 1, 0, 0, 5, 32'hDEADBEEF, 0, 0); #2; cyc();
        chk("load_valid", 32'(bus.EX_valid), 1);
        chk("load_rd", 32'(bus.EX_rd_sel), 5);
        chk("load_alu", bus.EX_alu_val, 32'hDEADBEEF);

        drive(1, 0, 0, 1, 0, 0, 5, 32'h11, 0, 0); #2; cyc();
        drive(1, 1, 0, 1, 0, 0, 6, 32'h22, 0, 0);
        repeat (3) begin #2; cyc(); end
        chk("stall_rd", 32'(bus.EX_rd_sel), 5);
        chk("stall_alu", bus.EX_alu_val, 32'h11);
        chk("stall_cnt3", 32'(bus.stall_cnt), 3);
        drive(1, 0, 0, 1, 0, 0, 6, 32'h22, 0, 0); #2; cyc();
        chk("release_rd", 32'(bus.EX_rd_sel), 6);
        chk("release_alu", bus.EX_alu_val, 32'h22);

        drive(1, 1, 1, 1, 1, 1, 9, 32'h33, 0, 0); #2; cyc();
        chk("flush_valid", 32'(bus.EX_valid), 0);
        chk("flush_ctl", {29'd0, bus.EX_wr_en, bus.EX_mem_en, bus.EX_mem_wr}, 0);
        chk("flush_cnt", 32'(bus.stall_cnt), 3);

        drive(1, 0, 0, 1, 0, 0, 7, 32'h100, 0, 0); #2; cyc();
        drive(1, 1, 0, 1, 0, 0, 7, 32'h200, 7, 7); #2;
        chk("fwd_id_hit1", 32'(bus.fwd_rs1_hit), 1);
        chk("fwd_id_val1", bus.fwd_rs1_val, 32'h200);
        chk("fwd_id_val2", bus.fwd_rs2_val, 32'h200);
        drive(0, 1, 0, 1, 0, 0, 7, 32'h200, 7, 7); #2;
        chk("fwd_ex_val1", bus.fwd_rs1_val, 32'h100);
        chk("fwd_ex_val2", bus.fwd_rs2_val, 32'h100);
        drive(0, 1, 0, 1, 0, 0, 7, 32'h200, 0, 7); #2;
        chk("fwd_zero_hit", 32'(bus.fwd_rs1_hit), 0);
        cyc();

        drive(1, 0, 0, 1, 1, 0, 3, 32'h44, 0, 3); #2;
        chk("lu_haz_id", 32'(bus.load_use_hazard), 1);
        chk("lu_nofwd", 32'(bus.fwd_rs2_hit), 0);
        chk("lu_rawsel", 32'(bus.EX_raw_sel), 0);
        cyc();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 3); #2;
        chk("lu_haz_ex", 32'(bus.load_use_hazard), 1);
        cyc();

        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) begin #2; cyc(); end
        chk("sat_cnt", 32'(bus.stall_cnt), CMAX);
        rst = 1; #2; cyc(); rst = 0;
        chk("rst_mid_stall", 32'(bus.stall_cnt), 0);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            #2;
            cyc();
        end
        rst = 0;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
